// File: rtl/render_resp_tx.sv
// Render-domain response transmitter: packs FRAME/STATUS words, queues them, and streams them MSB nibble first.
// Optional build macro RESP_CRC_EN appends a CRC-4 nibble (x^4+x+1, init 0) after each word.
module render_resp_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clk_render,
  input  logic                          rst_render,
  input  logic                          frame_done,
  input  logic                          status_req,
  input  logic                          create_done,
  input  logic                          busy_fd,
  input  logic                          busy_rm,
  input  logic [7:0]                    max_inst,
  output logic [3:0]                    tx_nibble,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef RESP_CRC_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  if (FRAME_CNT_W != 16) begin : g_bad_cnt_w
    $error("render_resp_tx: FRAME_CNT_W must be 16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("render_resp_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [FRAME_CNT_W-1:0]   r_frame_cnt;
  logic [FRAME_CNT_W-1:0]   w_frame_cnt_inc;
  logic                     r_pending;
  logic                     r_overflow;
  logic [31:0]              r_mem [FIFO_DEPTH];
  logic [LVL_W-1:0]         r_wr_ptr;
  logic [LVL_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         w_level;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_frame_push;
  logic                     w_stat_push;
  logic                     w_push;
  logic                     w_pop;
  logic [31:0]              w_frame_word;
  logic [31:0]              w_status_word;
  logic [31:0]              w_push_data;
  logic [31:0]              r_shreg;
  logic [3:0]               r_idx;
  logic                     w_last;
`ifdef RESP_CRC_EN
  logic [3:0]               r_crc;

  function automatic logic [3:0] crc4(input logic [31:0] data);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 31; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction
`endif

  assign w_level         = r_wr_ptr - r_rd_ptr;
  assign w_full          = (w_level == LVL_W'(FIFO_DEPTH));
  assign w_empty         = (w_level == '0);
  assign w_frame_cnt_inc = r_frame_cnt + FRAME_CNT_W'(1);

  // Frames win the single write port; a pending STATUS waits for a frame-free cycle with space.
  assign w_frame_push  = frame_done && !w_full;
  assign w_stat_push   = r_pending && !frame_done && !w_full;
  assign w_push        = w_frame_push || w_stat_push;
  assign w_pop         = (r_state == S_IDLE) && !w_empty;

  assign w_frame_word  = {4'hA, 4'h0, max_inst, w_frame_cnt_inc};
  assign w_status_word = {4'h5, 1'b0, r_overflow, busy_fd, busy_rm, create_done,
                          7'b0, max_inst, r_frame_cnt[7:0]};
  assign w_push_data   = frame_done ? w_frame_word : w_status_word;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      r_frame_cnt <= '0;
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (frame_done) r_frame_cnt <= w_frame_cnt_inc;
      // Requests arriving while one is already pending fold into it.
      r_pending <= w_stat_push ? 1'b0 : (r_pending | status_req);
      if (frame_done && w_full) r_overflow <= 1'b1;
      else if (w_stat_push)     r_overflow <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
    end
  end

  // NOTE: the word storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_render) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    w_last      = 1'b0;
    tx_nibble   = 4'h0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        tx_valid = 1'b1;
        w_last   = (r_idx == LAST_IDX);
`ifdef RESP_CRC_EN
        tx_nibble = (r_idx == 4'd8) ? r_crc : r_shreg[31:28];
`else
        tx_nibble = r_shreg[31:28];
`endif
        if (tx_ready && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      r_shreg <= '0;
      r_idx   <= '0;
`ifdef RESP_CRC_EN
      r_crc   <= '0;
`endif
    end else if (w_pop) begin
      r_shreg <= r_mem[r_rd_ptr[PTR_W-1:0]];
      r_idx   <= '0;
`ifdef RESP_CRC_EN
      r_crc   <= crc4(r_mem[r_rd_ptr[PTR_W-1:0]]);
`endif
    end else if (tx_valid && tx_ready) begin
      r_shreg <= {r_shreg[27:0], 4'h0};
      r_idx   <= r_idx + 4'd1;
    end
  end

  assign tx_last    = w_last;
  assign overflow   = r_overflow;
  assign fifo_level = w_level;

endmodule

// File: doc/render_resp_tx.md
Name: render_resp_tx

Overview:
Render-domain response transmitter. It is the transmit counterpart of the SPI command receiver: it packs render-side events and status into 32-bit response words, queues them, and serializes them MSB-nibble-first onto a 4-bit valid/ready stream. The stream feeds the quad-SPI output stage through the existing clock-domain-crossing FIFO. Sources are frame_driver (draw_done, busy), render_manager (busy) and the synchronized max_inst/create_done/status-request signals.

Parameters:
FIFO_DEPTH, 4, response word queue depth (power of 2, >=2)
FRAME_CNT_W, 16, frame counter width (fixed 16 in word format; other values rejected by elaboration assert)

Ports:
clk_render  in  1  render clock
rst_render  in  1  reset
frame_done  in  1  single-cycle pulse, frame_driver draw_done
status_req  in  1  single-cycle pulse, MCU status-read opcode (already synced)
create_done  in  1  scene creation complete (level)
busy_fd  in  1  frame_driver busy (level)
busy_rm  in  1  render_manager busy (level)
max_inst  in  8  instance count (level)
tx_nibble  out  4  current nibble
tx_valid  out  1  nibble valid
tx_ready  in  1  downstream accepts nibble
tx_last  out  1  final nibble of current word
overflow  out  1  sticky: a frame word was dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  words queued

Behaviour:
- Reset: rst_render, asynchronous, active-high; clock clk_render. All outputs 0, frame counter 0, FIFO empty, pending flag 0, serializer IDLE. Reset mid-word aborts the word; tx_valid drops asynchronously.
- Frame counter: +1 on every frame_done, wraps at 16'hFFFF->0, increments even if word dropped.
- FRAME word: {4'hA, 4'h0, max_inst[7:0], frame_cnt_post_increment[15:0]}.
- STATUS word: {4'h5, 1'b0, overflow, busy_fd, busy_rm, create_done, 7'b0, max_inst[7:0], frame_cnt[7:0]}; fields sampled on the enqueue cycle.
- Enqueue (one write per cycle, registered, at edge where condition true):
  - frame_done has priority. If FIFO full: word dropped, overflow<=1.
  - status_req sets pending_status. Repeated requests while pending coalesce into one. Pending is written on the first cycle with no frame_done and FIFO not full.
  - frame_done and status_req in the same cycle: FRAME enqueued that cycle, STATUS at the next eligible cycle.
  - Enqueuing STATUS clears overflow at the same edge; the STATUS word carries the pre-clear value.
  - Pending STATUS is never dropped; it waits for space.
- Serializer FSM:
  - IDLE: if FIFO non-empty, pop into shift register and go to SHIFT.
  - SHIFT: tx_valid=1, tx_nibble=shreg[31:28]. On tx_valid&&tx_ready, shift left 4 and increment nibble index 0..7. tx_last=1 at index 7. On the last handshake go to IDLE.
  - tx_valid is low for exactly one cycle between consecutive words.
  - While tx_valid&&!tx_ready, tx_nibble and tx_last are held stable.
- Latency: frame_done high in cycle 0, FIFO empty, serializer idle -> word written at end of cycle 0, popped at end of cycle 1, tx_valid=1 in cycle 2.
- fifo_level counts queued words excluding the one in the shift register. A same-cycle push and pop leaves the level unchanged. Full = FIFO_DEPTH.

Optional Feature:
Macro RESP_CRC_EN.
- Defined: a 9th nibble is sent after each word: CRC-4 (poly x^4+x+1, init 4'h0, MSB-first over the 8 data nibbles). tx_last moves to the 9th nibble.
- Undefined: 8 nibbles per word; no CRC logic synthesized.

Test Plan:
- Reset, max_inst=3, three frame_done pulses spaced 20 cycles, tx_ready=1 -> third word nibbles A,0,0,3,0,0,0,3 (0xA0030003). tx_valid rises 2 cycles after each pulse. tx_last is on nibble 8.
- create_done=1, busy_fd=1, busy_rm=0, max_inst=3, frame_cnt=0, status_req pulse -> 0x52800300 emitted.
- tx_ready=0, 6 frame_done pulses with FIFO_DEPTH=4 -> 1 word in shreg, 4 queued, 1 dropped. overflow=1, fifo_level=4. Next STATUS word has bit26=1; overflow reads 0 after it is enqueued.
- frame_done and status_req in the same cycle -> FRAME word then STATUS word, one idle cycle between them. 3 status_req pulses while pending -> one STATUS word.
- Random tx_ready toggling during a word -> nibbles stable while stalled, word bit-exact. Assert rst_render at nibble 4 -> tx_valid=0 immediately; after release no partial word is sent.
- RESP_CRC_EN defined -> 9 nibbles per word; 9th matches CRC-4 model; tx_last on nibble 9.
